onehot_pulse_decoder: RTL and testbench

- Inverse of the team's priority encoder: accepts a stream of binary indices and drives the matching one-hot line for a programmable number of cycles.
- Entries arrive over a valid/ready handshake and are buffered in a small FIFO.
- Sits between index-producing control logic (encoders, schedulers) and per-line enable/strobe consumers.

---
 rtl/onehot_pulse_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/onehot_pulse_decoder.sv | 107 ++++++++++
 tb/tb_onehot_pulse_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pulse_pkg.sv
// Shared types and helpers for the one-hot pulse decoder.
// Default widths match the decoder's default parameters.
package onehot_pulse_pkg;

  localparam int unsigned PKG_IDX_W  = 2;
  localparam int unsigned PKG_HOLD_W = 4;
  localparam int unsigned MAX_OUT_W  = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic [PKG_IDX_W-1:0]  idx;
    logic [PKG_HOLD_W-1:0] hold;
  } entry_t;

  // Callers truncate the result to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(
    input logic [7:0] idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read.
// The occupancy counter is one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign empty = (r_cnt == '0);
  assign level = r_cnt;

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Buffers index entries and drives the matching one-hot line
// for max(hold,1) cycles each, back to back when entries queue up.
module onehot_pulse_decoder
  import onehot_pulse_pkg::*;
#(
  parameter  int IDX_W  = 2,
  parameter  int DEPTH  = 4,
  parameter  int HOLD_W = 4,
  localparam int OUT_W  = 2**IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic [HOLD_W-1:0]      in_hold,
  output logic [OUT_W-1:0]       y,
  output logic                   y_valid,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [HOLD_W-1:0] hold;
  } ent_t;

  localparam int EW = $bits(ent_t);

  ent_t              w_wr;
  ent_t              w_rd;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic [HOLD_W-1:0] w_hold;
  logic [OUT_W-1:0]  w_oh;

  state_e            r_state;
  logic [HOLD_W-1:0] r_cnt;
  logic [OUT_W-1:0]  r_y;
  logic              r_yv;

  assign w_wr.idx  = in_idx;
  assign w_wr.hold = in_hold;
  assign w_push    = in_valid && !w_full;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wr),
    .rdata (w_rd),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  // Popping on the last drive cycle gives gap-free pulses.
  assign w_last = (r_state == DRIVE) && (r_cnt == HOLD_W'(1));
  assign w_pop  = !w_empty && ((r_state == IDLE) || w_last);
  assign w_hold = (w_rd.hold == '0) ? HOLD_W'(1) : w_rd.hold;
  assign w_oh   = OUT_W'(onehot(8'(w_rd.idx)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_yv    <= 1'b0;
    end else if (w_pop) begin
      r_state <= DRIVE;
      r_cnt   <= w_hold;
      r_y     <= w_oh;
      r_yv    <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_y  <= '0;
          r_yv <= 1'b0;
        end
        DRIVE: begin
          if (w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_y     <= '0;
            r_yv    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign y        = r_y;
  assign y_valid  = r_yv;
  assign in_ready = !w_full;
  assign busy     = (r_state == DRIVE) || !w_empty;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Bench for onehot_pulse_decoder: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_onehot_pulse_decoder;

  localparam int IDX_W  = 2;
  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [IDX_W-1:0]  in_idx = '0;
  logic [HOLD_W-1:0] in_hold = '0;
  logic              in_ready;
  logic [3:0]        y;
  logic              y_valid;
  logic              busy;
  logic [2:0]        level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onehot_pulse_decoder #(
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_idx   (in_idx),
    .in_hold  (in_hold),
    .y        (y),
    .y_valid  (y_valid),
    .busy     (busy),
    .level    (level)
  );

  typedef struct {
    int idx;
    int hold;
  } ment_t;

  // Model: queue of waiting entries, current line, cycles left.
  ment_t mq[$];
  int    m_idx = 0;
  int    m_rem = 0;
  bit    chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    ment_t e;
    bit    do_push;
    if (rst) begin
      mq.delete();
      m_rem = 0;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      if (m_rem > 1) begin
        m_rem--;
      end else if (mq.size() > 0) begin
        e     = mq.pop_front();
        m_idx = e.idx;
        m_rem = (e.hold == 0) ? 1 : e.hold;
      end else begin
        m_rem = 0;
      end
      if (do_push) begin
        e.idx  = int'(in_idx);
        e.hold = int'(in_hold);
        mq.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [3:0] ey;
    @(negedge clk);
    if (chk_en) begin
      ey = (m_rem > 0) ? 4'(1 << m_idx) : 4'd0;
      cmp("m_y", 32'(y), 32'(ey));
      cmp("m_yv", 32'(y_valid), 32'(m_rem > 0));
      cmp("m_busy", 32'(busy), 32'((m_rem > 0) || (mq.size() > 0)));
      cmp("m_level", 32'(level), 32'(mq.size()));
      cmp("m_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      cmp("m_onehot0", 32'($onehot0(y)), 32'd1);
    end
  end

  logic [3:0] e_b2b [7] = '{4'h0, 4'h1, 4'h1, 4'h8, 4'h2, 4'h2, 4'h0};

  initial begin
    int nacc;
    int cyc;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    cmp("rst_y", 32'(y), 32'd0);
    cmp("rst_yv", 32'(y_valid), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_level", 32'(level), 32'd0);
    cmp("rst_ready", 32'(in_ready), 32'd1);

    // Single entry idx=2 hold=3
    in_valid = 1'b1; in_idx = 2'd2; in_hold = 4'd3;
    @(negedge clk); in_valid = 1'b0;
    cmp("t1_c0", 32'(y), 32'h0);
    @(negedge clk); cmp("t1_c1", 32'(y), 32'h4);
    @(negedge clk); cmp("t1_c2", 32'(y), 32'h4);
    @(negedge clk); cmp("t1_c3", 32'(y), 32'h4);
    @(negedge clk); cmp("t1_c4", 32'(y), 32'h0);
    cmp("t1_busy", 32'(busy), 32'd0);

    // hold=0 behaves as one cycle
    in_valid = 1'b1; in_idx = 2'd1; in_hold = 4'd0;
    @(negedge clk); in_valid = 1'b0;
    cmp("h0_c0", 32'(y), 32'h0);
    @(negedge clk); cmp("h0_c1", 32'(y), 32'h2);
    @(negedge clk); cmp("h0_c2", 32'(y), 32'h0);

    // Back-to-back pulses without gaps
    in_valid = 1'b1; in_idx = 2'd0; in_hold = 4'd2;
    @(negedge clk); cmp("b2b_0", 32'(y), 32'(e_b2b[0]));
    in_idx = 2'd3; in_hold = 4'd1;
    @(negedge clk); cmp("b2b_1", 32'(y), 32'(e_b2b[1]));
    in_idx = 2'd1; in_hold = 4'd2;
    @(negedge clk); cmp("b2b_2", 32'(y), 32'(e_b2b[2]));
    in_valid = 1'b0;
    for (int k = 3; k < 7; k++) begin
      @(negedge clk);
      cmp($sformatf("b2b_%0d", k), 32'(y), 32'(e_b2b[k]));
    end

    // Fill: in_valid held high, hold=15
    nacc = 0; cyc = 0;
    in_valid = 1'b1; in_idx = 2'd0; in_hold = 4'd15;
    while (nacc < 5 && cyc < 50) begin
      if (in_ready) nacc++;
      @(negedge clk);
      in_idx = 2'(nacc);
      cyc++;
    end
    cmp("fill_acc5", 32'(nacc), 32'd5);
    cmp("fill_level", 32'(level), 32'd4);
    cmp("fill_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (in_ready) nacc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    cmp("fill_total", 32'(nacc), 32'd5);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    cmp("fill_drain", 32'(busy), 32'd0);

    // Reset during the 2nd cycle of a pulse with 2 queued
    in_valid = 1'b1; in_idx = 2'd3; in_hold = 4'd5;
    @(negedge clk); in_idx = 2'd0; in_hold = 4'd1;
    @(negedge clk); in_idx = 2'd1; in_hold = 4'd1;
    @(negedge clk); in_valid = 1'b0;
    cmp("mr_y_pre", 32'(y), 32'h8);
    cmp("mr_lvl_pre", 32'(level), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("mr_y", 32'(y), 32'h0);
    cmp("mr_level", 32'(level), 32'd0);
    cmp("mr_ready", 32'(in_ready), 32'd1);
    cmp("mr_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cmp("mr_quiet", 32'(y), 32'h0);
    end

    // Random traffic, source holds data until accepted
    nacc = 0; cyc = 0;
    while (nacc < 200 && cyc < 20000) begin
      bit will_acc;
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_idx   = 2'($urandom_range(0, 3));
        in_hold  = ($urandom_range(0, 15) == 0) ? 4'd15
                   : 4'($urandom_range(0, 4));
      end
      will_acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (will_acc) begin
        nacc++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    cmp("rnd_count", 32'(nacc), 32'd200);
    cyc = 0;
    while (busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    cmp("rnd_drain", 32'(busy), 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
